// File: rtl/dff_response_checker_if.sv
// Handshake and result bundle between a D flip-flop response checker and
// whatever drives the stimulus and observes the results.
//   master : stimulus source / result consumer (bench or board logic)
//   slave  : the checker itself
interface dff_response_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             D;
    logic             Q;
    logic             nQ;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] first_err_idx;
    logic             first_err_valid;

    modport master (
        output start, D, Q, nQ,
        input  busy, done, pass, err_count, first_err_idx, first_err_valid
    );

    modport slave (
        input  start, D, Q, nQ,
        output busy, done, pass, err_count, first_err_idx, first_err_valid
    );
endinterface

// File: rtl/dff_response_checker.sv
// Hardware checker for a D flip-flop under test. A LATENCY-deep copy of D is
// compared against the DUT's Q for CHECK_LEN cycles per run; the run yields a
// saturating mismatch count, the index of the first mismatch and a pass flag.
//
// Optional build macro: CHECK_NQ_EN -- when defined, a cycle also counts as a
// mismatch if nQ is not the complement of Q. Without it nQ is ignored.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | after reset, waiting for start
// WARMUP | LATENCY cycles letting the delay line line up, no compares
// CHECK  | one compare per cycle, idx 0..CHECK_LEN-1
// DONE   | results held, done=1, waiting for the next start
module dff_response_checker #(
    parameter int CHECK_LEN = 64,
    parameter int LATENCY   = 1,
    parameter int CNT_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dff_response_checker_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WARMUP, CHECK, DONE} state_t;

    localparam logic [15:0]      LAST_IDX  = 16'(CHECK_LEN - 1);
    localparam logic [2:0]       WARM_INIT = 3'(LATENCY);
    localparam logic [CNT_W-1:0] ERR_MAX   = '1;

    state_t             state;
    logic [LATENCY-1:0] dline;
    logic [2:0]         warm_cnt;
    logic [15:0]        idx;
    logic               busy_r;
    logic               done_r;
    logic               pass_r;
    logic [CNT_W-1:0]   err_count_r;
    logic [CNT_W-1:0]   first_err_idx_r;
    logic               first_err_valid_r;

    logic               expected;
    logic               mismatch;
    logic [CNT_W-1:0]   err_next;

    assign expected = dline[LATENCY-1];

    // Per-cycle mismatch; Q and nQ errors in one cycle count once.
    always_comb begin
        mismatch = 1'b0;
`ifdef CHECK_NQ_EN
        mismatch = (bus.Q != expected) || (bus.nQ != ~bus.Q);
`else
        mismatch = (bus.Q != expected);
`endif
    end

`ifndef CHECK_NQ_EN
    // nQ stays on the port list so boards need no rewiring between builds.
    logic unused_nq;
    assign unused_nq = bus.nQ;
`endif

    // Count of mismatches including this cycle, clamped at the top value.
    assign err_next = (mismatch && (err_count_r != ERR_MAX))
                    ? err_count_r + CNT_W'(1) : err_count_r;

    // Delay line runs in every state so it is already primed when a run starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dline <= '0;
        end else begin
            dline[0] <= bus.D;
            for (int i = 1; i < LATENCY; i++) begin
                dline[i] <= dline[i-1];
            end
        end
    end

    // Run sequencing and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            warm_cnt          <= '0;
            idx               <= '0;
            busy_r            <= 1'b0;
            done_r            <= 1'b0;
            pass_r            <= 1'b0;
            err_count_r       <= '0;
            first_err_idx_r   <= '0;
            first_err_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state             <= WARMUP;
                        warm_cnt          <= WARM_INIT;
                        busy_r            <= 1'b1;
                        done_r            <= 1'b0;
                        pass_r            <= 1'b0;
                        err_count_r       <= '0;
                        first_err_idx_r   <= '0;
                        first_err_valid_r <= 1'b0;
                    end
                end
                WARMUP: begin
                    if (warm_cnt == 3'd1) begin
                        state <= CHECK;
                        idx   <= '0;
                    end else begin
                        warm_cnt <= warm_cnt - 3'd1;
                    end
                end
                CHECK: begin
                    err_count_r <= err_next;
                    if (mismatch && !first_err_valid_r) begin
                        first_err_valid_r <= 1'b1;
                        first_err_idx_r   <= CNT_W'(idx);
                    end
                    if (idx == LAST_IDX) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        // err_next so a mismatch on the last compare is reflected
                        pass_r <= (err_next == '0);
                    end else begin
                        idx <= idx + 16'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy            = busy_r;
    assign bus.done            = done_r;
    assign bus.pass            = pass_r;
    assign bus.err_count       = err_count_r;
    assign bus.first_err_idx   = first_err_idx_r;
    assign bus.first_err_valid = first_err_valid_r;
endmodule

// File: doc/dff_response_checker.md
Name: dff_response_checker

Overview:
Hardware checker for the D flip-flop exercise. It watches the same D/clk stimulus as the flip-flop under test, samples the DUT's Q/nQ every clock, and compares them against an internally delayed copy of D. It reports mismatch count, first-failure index and a pass flag. It sits next to the DUT on the board or in a self-checking bench, replacing manual waveform inspection.

Parameters:
CHECK_LEN, 64, number of compared clock cycles per run (1..2^16-1)
LATENCY, 1, expected D-to-Q delay in clock cycles (1..4)
CNT_W, 8, width of error counter and first-error index

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse, begins a run when idle
D  input  1  stimulus bit fed to the DUT
Q  input  1  DUT output
nQ  input  1  DUT complementary output
busy  output  1  high in WARMUP and CHECK
done  output  1  high in DONE; holds until next accepted start
pass  output  1  valid when done: 1 if err_count==0
err_count  output  CNT_W  mismatching cycles, saturating
first_err_idx  output  CNT_W  CHECK-cycle index of first mismatch (0-based, truncated to CNT_W)
first_err_valid  output  1  at least one mismatch recorded this run

Behaviour:
- Reset: async on rst_n low. State=IDLE, all outputs 0, delay line 0. Reset mid-run aborts; no partial results are kept.
- Delay line: LATENCY-deep shift register. dline[0] <= D on every rising clk in every state. expected = dline[LATENCY-1].
- Sampling: at each rising edge in CHECK, Q/nQ as seen before that edge are compared against expected, also as seen before that edge. An ideal DFF with LATENCY=1 gives zero mismatches.
- Mismatch at a cycle: Q != expected, or (with CHECK_NQ_EN) nQ != ~Q. One cycle counts as at most one error.
- FSM:
  - IDLE: start=1 -> WARMUP; clear err_count, first_err_*, pass, done; load warm counter=LATENCY.
  - WARMUP: no compares. Decrement each cycle; at 1 -> CHECK; idx=0.
  - CHECK: compare each cycle; idx increments. After the compare at idx==CHECK_LEN-1 -> DONE.
  - DONE: done=1; pass=(final err_count==0), registered on DONE entry. start=1 -> WARMUP with the same clears as IDLE.
- busy=1 exactly in WARMUP and CHECK. Latency from start to done is LATENCY+CHECK_LEN+1 clocks.
- start while busy: ignored.
- err_count saturates at 2^CNT_W-1 and never wraps. first_err_idx is written only on the first mismatch of a run.
- A mismatch on the final CHECK cycle is counted before the DONE entry, and pass reflects it.

Optional Feature:
CHECK_NQ_EN: when defined, the nQ complement check is part of the mismatch condition. When undefined, nQ is ignored: the port stays present and unused, and only Q is compared.

Test Plan:
- Ideal DFF model, LATENCY=1, CHECK_LEN=16, D toggling irregularly (5/5/5/10-clock holds) -> done 18 clocks after start, pass=1, err_count=0, first_err_valid=0.
- Q stuck at 0, D=1010... starting with 1, CHECK_LEN=16 -> err_count=8, first_err_idx=0, first_err_valid=1, pass=0.
- nQ stuck equal to Q, Q correct -> with CHECK_NQ_EN: err_count=16, pass=0; without: err_count=0, pass=1.
- CNT_W=3, Q always inverted, CHECK_LEN=16 -> err_count saturates at 7, first_err_idx=0.
- rst_n pulsed low at CHECK idx 5 -> busy/done/pass/err_count all 0 immediately; start pulses during a later busy run are ignored and the run completes normally.
- LATENCY=2, DUT modelled as two DFFs in series -> pass=1; same run with a single DFF and D=1100... -> err_count=CHECK_LEN/2.
